// File: rtl/branch_target_predictor_if.sv
// Purpose: fetch-side lookup, prediction result and resolution-update bundle
//          for branch_target_predictor.
// Signals:
//   i_lookup_pc  next PC to look up          i_stall      freeze lookup registers
//   o_is_branch  BTB hit for current PC      o_prediction predicted taken
//   o_target     predicted target            o_hit_count  saturating correct-prediction count
//   i_upd_valid  resolution this cycle       i_upd_pc     PC of resolved branch
//   i_upd_taken  actual outcome              i_upd_target actual taken target
// Modports: master = fetch/resolution side, slave = predictor.
interface branch_target_predictor_if #(
   parameter int unsigned ADDR_WIDTH = 26
);
   logic [ADDR_WIDTH-1:0] i_lookup_pc;
   logic                  i_stall;
   logic                  o_is_branch;
   logic                  o_prediction;
   logic [ADDR_WIDTH-1:0] o_target;
   logic                  i_upd_valid;
   logic [ADDR_WIDTH-1:0] i_upd_pc;
   logic                  i_upd_taken;
   logic [ADDR_WIDTH-1:0] i_upd_target;
   logic [15:0]           o_hit_count;

   modport master (
      output i_lookup_pc, i_stall, i_upd_valid, i_upd_pc, i_upd_taken, i_upd_target,
      input  o_is_branch, o_prediction, o_target, o_hit_count
   );

   modport slave (
      input  i_lookup_pc, i_stall, i_upd_valid, i_upd_pc, i_upd_taken, i_upd_target,
      output o_is_branch, o_prediction, o_target, o_hit_count
   );
endinterface

// File: rtl/branch_target_predictor.sv
// Purpose: direct-mapped BTB with 2-bit saturating counters feeding fetch_unit.
//          Lookup is indexed by next-PC and the entry is captured at the clock
//          edge, so outputs align with the current PC one cycle later.
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous active-high reset
//   bp   branch_target_predictor_if.slave (lookup, prediction, update, hit count)
// Config: define BP_GSHARE_EN to XOR the table index with a global history register.
module branch_target_predictor #(
   parameter int unsigned ADDR_WIDTH = 26,
   parameter int unsigned INDEX_BITS = 6
) (
   input logic                      clk,
   input logic                      rst,
   branch_target_predictor_if.slave bp
);
   localparam int unsigned TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
   localparam int unsigned ENTRIES  = 1 << INDEX_BITS;

   // Entry storage
   logic                  vld_q [ENTRIES];
   logic [TAG_BITS-1:0]   tag_q [ENTRIES];
   logic [ADDR_WIDTH-1:0] tgt_q [ENTRIES];
   logic [1:0]            ctr_q [ENTRIES];

   // Lookup registers: index/tag of the registered PC plus the captured entry
   logic                  lk_vld_q, lk_vld_d;
   logic [INDEX_BITS-1:0] idx_q, idx_d;
   logic [TAG_BITS-1:0]   ltag_q, ltag_d;
   logic                  e_vld_q, e_vld_d;
   logic [TAG_BITS-1:0]   e_tag_q, e_tag_d;
   logic [1:0]            e_ctr_q, e_ctr_d;
   logic [ADDR_WIDTH-1:0] e_tgt_q, e_tgt_d;
   logic [15:0]           cnt_q;

   logic [INDEX_BITS-1:0] lk_idx, up_idx;
   logic [TAG_BITS-1:0]   lk_tag, up_tag;
   logic                  up_hit, up_correct;
   logic [1:0]            up_ctr_new;
   logic [ADDR_WIDTH-1:0] up_tgt_new;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{bp.i_lookup_pc[1:0], bp.i_upd_pc[1:0]};

   assign lk_tag = bp.i_lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
   assign up_tag = bp.i_upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];

`ifdef BP_GSHARE_EN
   localparam int unsigned GHR_BITS = INDEX_BITS;
   logic [GHR_BITS-1:0] ghr_q;

   // Update hashes with the history before its own shift
   always_ff @(posedge clk) begin
      if (rst)                 ghr_q <= '0;
      else if (bp.i_upd_valid) ghr_q <= {ghr_q[GHR_BITS-2:0], bp.i_upd_taken};
   end

   assign lk_idx = bp.i_lookup_pc[INDEX_BITS+1:2] ^ ghr_q;
   assign up_idx = bp.i_upd_pc[INDEX_BITS+1:2] ^ ghr_q;
`else
   assign lk_idx = bp.i_lookup_pc[INDEX_BITS+1:2];
   assign up_idx = bp.i_upd_pc[INDEX_BITS+1:2];
`endif

   // Update-side entry evaluation and new entry contents
   always_comb begin
      up_hit     = vld_q[up_idx] && (tag_q[up_idx] == up_tag);
      up_ctr_new = bp.i_upd_taken ? 2'b10 : 2'b01;
      up_tgt_new = bp.i_upd_target;
      up_correct = !bp.i_upd_taken;
      if (up_hit) begin
         up_correct = (ctr_q[up_idx][1] == bp.i_upd_taken);
         up_tgt_new = bp.i_upd_taken ? bp.i_upd_target : tgt_q[up_idx];
         if (bp.i_upd_taken)
            up_ctr_new = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
         else
            up_ctr_new = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
      end
   end

   // Table write; reset wins over a same-cycle update
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            vld_q[i] <= 1'b0;
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= 2'b01;
         end
      end else if (bp.i_upd_valid) begin
         vld_q[up_idx] <= 1'b1;
         tag_q[up_idx] <= up_tag;
         tgt_q[up_idx] <= up_tgt_new;
         ctr_q[up_idx] <= up_ctr_new;
      end
   end

   // Lookup next-state: a new lookup captures the pre-update entry; a stalled
   // lookup re-reads its held index including this cycle's update.
   always_comb begin
      lk_vld_d = lk_vld_q;
      idx_d    = idx_q;
      ltag_d   = ltag_q;
      e_vld_d  = vld_q[idx_q];
      e_tag_d  = tag_q[idx_q];
      e_ctr_d  = ctr_q[idx_q];
      e_tgt_d  = tgt_q[idx_q];
      if (!bp.i_stall) begin
         lk_vld_d = 1'b1;
         idx_d    = lk_idx;
         ltag_d   = lk_tag;
         e_vld_d  = vld_q[lk_idx];
         e_tag_d  = tag_q[lk_idx];
         e_ctr_d  = ctr_q[lk_idx];
         e_tgt_d  = tgt_q[lk_idx];
      end else if (bp.i_upd_valid && (up_idx == idx_q)) begin
         e_vld_d  = 1'b1;
         e_tag_d  = up_tag;
         e_ctr_d  = up_ctr_new;
         e_tgt_d  = up_tgt_new;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lk_vld_q <= 1'b0;
         idx_q    <= '0;
         ltag_q   <= '0;
         e_vld_q  <= 1'b0;
         e_tag_q  <= '0;
         e_ctr_q  <= 2'b01;
         e_tgt_q  <= '0;
         cnt_q    <= '0;
      end else begin
         lk_vld_q <= lk_vld_d;
         idx_q    <= idx_d;
         ltag_q   <= ltag_d;
         e_vld_q  <= e_vld_d;
         e_tag_q  <= e_tag_d;
         e_ctr_q  <= e_ctr_d;
         e_tgt_q  <= e_tgt_d;
         if (bp.i_upd_valid && up_correct && (cnt_q != 16'hFFFF))
            cnt_q <= cnt_q + 16'd1;
      end
   end

   // Outputs are zero until a post-reset lookup has been captured and on a miss
   logic out_hit;
   assign out_hit         = lk_vld_q && e_vld_q && (e_tag_q == ltag_q);
   assign bp.o_is_branch  = out_hit;
   assign bp.o_prediction = out_hit && e_ctr_q[1];
   assign bp.o_target     = out_hit ? e_tgt_q : '0;
   assign bp.o_hit_count  = cnt_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed vector bench for branch_target_predictor: each record gives the
// inputs sampled at one clock edge and the outputs expected just after it.
module tb_branch_target_predictor;
   localparam int unsigned AW = 26;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_target_predictor_if #(.ADDR_WIDTH(AW)) bus ();

   branch_target_predictor #(.ADDR_WIDTH(AW), .INDEX_BITS(6)) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bus)
   );

   typedef struct {
      logic          rst;
      logic          stall;
      logic [AW-1:0] lpc;
      logic          uv;
      logic [AW-1:0] upc;
      logic          ut;
      logic [AW-1:0] utgt;
      logic          eb;
      logic          ep;
      logic [AW-1:0] et;
      logic [15:0]   ec;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   function automatic vec_t mk(logic r, logic s, logic [AW-1:0] lpc, logic uv,
                               logic [AW-1:0] upc, logic ut, logic [AW-1:0] utgt,
                               logic eb, logic ep, logic [AW-1:0] et, logic [15:0] ec);
      vec_t v;
      v.rst = r; v.stall = s; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut;
      v.utgt = utgt; v.eb = eb; v.ep = ep; v.et = et; v.ec = ec;
      return v;
   endfunction

   task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(logic r, logic s, logic [AW-1:0] lpc, logic uv,
                        logic [AW-1:0] upc, logic ut, logic [AW-1:0] utgt);
      rst = r;
      bus.i_stall = s;
      bus.i_lookup_pc = lpc;
      bus.i_upd_valid = uv;
      bus.i_upd_pc = upc;
      bus.i_upd_taken = ut;
      bus.i_upd_target = utgt;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(string tag, int idx, logic eb, logic ep,
                            logic [AW-1:0] et, logic [15:0] ec);
      check({tag, ".is_branch"},  idx, 32'(bus.o_is_branch),  32'(eb));
      check({tag, ".prediction"}, idx, 32'(bus.o_prediction), 32'(ep));
      check({tag, ".target"},     idx, 32'(bus.o_target),     32'(et));
      check({tag, ".hit_count"},  idx, 32'(bus.o_hit_count),  32'(ec));
   endtask

   initial begin
      rst = 1'b1;
      bus.i_stall = 1'b0;
      bus.i_lookup_pc = '0;
      bus.i_upd_valid = 1'b0;
      bus.i_upd_pc = '0;
      bus.i_upd_taken = 1'b0;
      bus.i_upd_target = '0;

      //                rst stall lookup      uv upd_pc       t  upd_tgt      eb ep target       cnt
      // reset, then first lookup misses
      vecs.push_back(mk(1, 0, 26'h0000040, 0, 26'h0,       0, 26'h0,      0, 0, 26'h0,     0));
      vecs.push_back(mk(0, 0, 26'h0000040, 0, 26'h0,       0, 26'h0,      0, 0, 26'h0,     0));
      // taken allocate on same index as lookup: lookup sees pre-update entry
      vecs.push_back(mk(0, 0, 26'h0000040, 1, 26'h0000040, 1, 26'h100,    0, 0, 26'h0,     0));
      vecs.push_back(mk(0, 0, 26'h0000040, 0, 26'h0,       0, 26'h0,      1, 1, 26'h100,   0));
      // three not-taken: 10->01->00->00, target kept
      vecs.push_back(mk(0, 0, 26'h0000040, 1, 26'h0000040, 0, 26'h3FC,    1, 1, 26'h100,   0));
      vecs.push_back(mk(0, 0, 26'h0000040, 1, 26'h0000040, 0, 26'h3FC,    1, 0, 26'h100,   1));
      vecs.push_back(mk(0, 0, 26'h0000040, 1, 26'h0000040, 0, 26'h3FC,    1, 0, 26'h100,   2));
      vecs.push_back(mk(0, 0, 26'h0000040, 0, 26'h0,       0, 26'h0,      1, 0, 26'h100,   2));
      // taken (00->01), then thread-1 alias of same index misses
      vecs.push_back(mk(0, 0, 26'h0000040, 1, 26'h0000040, 1, 26'h100,    1, 0, 26'h100,   2));
      vecs.push_back(mk(0, 0, 26'h2000040, 0, 26'h0,       0, 26'h0,      0, 0, 26'h0,     2));
      // taken with new target (01->10), then up to saturation at 11
      vecs.push_back(mk(0, 0, 26'h0000040, 1, 26'h0000040, 1, 26'h140,    1, 0, 26'h100,   2));
      vecs.push_back(mk(0, 0, 26'h0000040, 0, 26'h0,       0, 26'h0,      1, 1, 26'h140,   2));
      vecs.push_back(mk(0, 0, 26'h0000040, 1, 26'h0000040, 1, 26'h140,    1, 1, 26'h140,   3));
      vecs.push_back(mk(0, 0, 26'h0000040, 1, 26'h0000040, 1, 26'h140,    1, 1, 26'h140,   4));
      vecs.push_back(mk(0, 0, 26'h0000040, 1, 26'h0000040, 0, 26'h3FC,    1, 1, 26'h140,   4));
      vecs.push_back(mk(0, 0, 26'h0000040, 0, 26'h0,       0, 26'h0,      1, 1, 26'h140,   4));
      // not-taken miss counts as correct and is still allocated
      vecs.push_back(mk(0, 0, 26'h0000080, 1, 26'h00000C0, 0, 26'h3FC,    0, 0, 26'h0,     5));
      vecs.push_back(mk(0, 0, 26'h00000C0, 0, 26'h0,       0, 26'h0,      1, 0, 26'h3FC,   5));
      // stall holding 0x80 while it is trained: visible the next cycle
      vecs.push_back(mk(0, 0, 26'h0000080, 0, 26'h0,       0, 26'h0,      0, 0, 26'h0,     5));
      vecs.push_back(mk(0, 1, 26'h0000040, 1, 26'h0000080, 1, 26'h200,    1, 1, 26'h200,   5));
      vecs.push_back(mk(0, 1, 26'h0000040, 0, 26'h0,       0, 26'h0,      1, 1, 26'h200,   5));
      vecs.push_back(mk(0, 0, 26'h0000040, 0, 26'h0,       0, 26'h0,      1, 1, 26'h140,   5));
      // reset with a concurrent update: everything cleared, update dropped
      vecs.push_back(mk(1, 0, 26'h0000040, 1, 26'h0000080, 1, 26'h200,    0, 0, 26'h0,     0));
      vecs.push_back(mk(0, 1, 26'h0000040, 0, 26'h0,       0, 26'h0,      0, 0, 26'h0,     0));
      vecs.push_back(mk(0, 0, 26'h0000040, 0, 26'h0,       0, 26'h0,      0, 0, 26'h0,     0));
      vecs.push_back(mk(0, 0, 26'h0000080, 0, 26'h0,       0, 26'h0,      0, 0, 26'h0,     0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].stall, vecs[i].lpc, vecs[i].uv,
               vecs[i].upc, vecs[i].ut, vecs[i].utgt);
         check_out("vec", i, vecs[i].eb, vecs[i].ep, vecs[i].et, vecs[i].ec);
      end

      // Train four adjacent indices taken with distinct targets, then read back
      for (int k = 0; k < 4; k++)
         drive(0, 0, 26'h0, 1, 26'h1000 + 26'(k * 4), 1, 26'h8000 + 26'(k * 16));
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 26'h1000 + 26'(k * 4), 0, 26'h0, 0, 26'h0);
         check_out("multi", k, 1'b1, 1'b1, 26'h8000 + 26'(k * 16), 16'd0);
      end
      // One not-taken on a weakly-taken entry flips the prediction, keeps target
      drive(0, 0, 26'h1000, 1, 26'h1000, 0, 26'h3FC);
      drive(0, 0, 26'h1000, 0, 26'h0, 0, 26'h0);
      check_out("flip", 0, 1'b1, 1'b0, 26'h8000, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
